// File: rtl/hand_select_ctrl.sv
// hand_select_ctrl: keyboard-driven card cursor with play/draw request handshake.
// Scancodes move a cursor over the hand and raise a level request toward the
// game logic, which acknowledges it or lets it time out.
module hand_select_ctrl #(
  parameter logic [7:0]  KEY_NEXT = 8'h1D,
  parameter logic [7:0]  KEY_PREV = 8'h1B,
  parameter logic [7:0]  KEY_PLAY = 8'h5A,
  parameter logic [7:0]  KEY_DRAW = 8'h23,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic       CLOCK_50,
  input  logic       i_rst_n,
  input  logic       i_key_valid,
  input  logic [7:0] i_key_code,
  input  logic       i_turn_active,
  input  logic [6:0] i_hand_size,
  input  logic       i_play_ack,
  input  logic       i_draw_ack,
  output logic [6:0] o_cursor,
  output logic       o_play_req,
  output logic       o_draw_req,
  output logic       o_timeout,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SELECT    = 2'd1,
    PLAY_WAIT = 2'd2,
    DRAW_WAIT = 2'd3
  } state_t;

  localparam logic [7:0]  BREAK_CODE  = 8'hF0;
  localparam logic [15:0] TIMEOUT_M1  = TIMEOUT - 16'd1;

  state_t      state_q,    state_d;
  logic [6:0]  cursor_q,   cursor_d;
  logic        play_req_q, play_req_d;
  logic        draw_req_q, draw_req_d;
  logic        timeout_q,  timeout_d;
  logic        brk_q,      brk_d;
  logic [15:0] cnt_q,      cnt_d;

  // A key counts only when it is neither the break prefix nor the byte after it.
  logic       key_hit;
  logic       hand_empty;
  logic [6:0] last_idx;
  state_t     exit_state;

  assign key_hit    = i_key_valid && !brk_q && (i_key_code != BREAK_CODE);
  assign hand_empty = (i_hand_size == 7'd0);
  assign last_idx   = i_hand_size - 7'd1;
  assign exit_state = i_turn_active ? SELECT : IDLE;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    // NOTE: every _d starts from its held value so no path through the
    // decision tree leaves a variable unassigned, which would infer a latch.
    state_d    = state_q;
    cursor_d   = cursor_q;
    play_req_d = play_req_q;
    draw_req_d = draw_req_q;
    timeout_d  = 1'b0;
    brk_d      = brk_q;
    cnt_d      = cnt_q;

    // The break flag tracks the byte stream in every state, waits included.
    if (i_key_valid) begin
      brk_d = brk_q ? 1'b0 : (i_key_code == BREAK_CODE);
    end

    unique case (state_q)
      IDLE: begin
        if (i_turn_active) state_d = SELECT;
      end

      SELECT: begin
        if (!i_turn_active) begin
          state_d = IDLE;
        end else if (key_hit) begin
          if (i_key_code == KEY_NEXT && !hand_empty) begin
            cursor_d = (cursor_q == last_idx) ? 7'd0 : cursor_q + 7'd1;
          end else if (i_key_code == KEY_PREV && !hand_empty) begin
            cursor_d = (cursor_q == 7'd0) ? last_idx : cursor_q - 7'd1;
          end else if (i_key_code == KEY_PLAY && !hand_empty) begin
            play_req_d = 1'b1;
            cnt_d      = 16'd0;
            state_d    = PLAY_WAIT;
          end else if (i_key_code == KEY_DRAW) begin
            draw_req_d = 1'b1;
            cnt_d      = 16'd0;
            state_d    = DRAW_WAIT;
          end
        end
      end

      PLAY_WAIT: begin
        // An ack in the timeout cycle wins, so it is tested first.
        if (i_play_ack) begin
          play_req_d = 1'b0;
          cnt_d      = 16'd0;
          state_d    = exit_state;
        end else if (cnt_q == TIMEOUT_M1) begin
          play_req_d = 1'b0;
          timeout_d  = 1'b1;
          cnt_d      = 16'd0;
          state_d    = exit_state;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DRAW_WAIT: begin
        if (i_draw_ack) begin
          draw_req_d = 1'b0;
          cnt_d      = 16'd0;
          state_d    = exit_state;
        end else if (cnt_q == TIMEOUT_M1) begin
          draw_req_d = 1'b0;
          timeout_d  = 1'b1;
          cnt_d      = 16'd0;
          state_d    = exit_state;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Keep the cursor inside the hand; overrides any move decided above.
    // The cursor is left untouched while a play is outstanding.
    if (state_q != PLAY_WAIT) begin
      if (hand_empty) begin
        cursor_d = 7'd0;
      end else if (cursor_q >= i_hand_size) begin
        cursor_d = last_idx;
      end
    end
  end

  // Register all state and outputs; synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values, independent of statement order.
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cursor_q   <= 7'd0;
      play_req_q <= 1'b0;
      draw_req_q <= 1'b0;
      timeout_q  <= 1'b0;
      brk_q      <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      play_req_q <= play_req_d;
      draw_req_q <= draw_req_d;
      timeout_q  <= timeout_d;
      brk_q      <= brk_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_cursor   = cursor_q;
  assign o_play_req = play_req_q;
  assign o_draw_req = draw_req_q;
  assign o_timeout  = timeout_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_hand_select_ctrl.sv
// Directed testbench for hand_select_ctrl with a short TIMEOUT of 16 cycles.
// Inputs change and outputs are sampled on the falling edge.
module tb_hand_select_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       turn;
  logic [6:0] hand_size;
  logic       play_ack;
  logic       draw_ack;
  logic [6:0] cursor;
  logic       play_req;
  logic       draw_req;
  logic       timeout;
  logic [1:0] state;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  hand_select_ctrl #(.TIMEOUT(16'd16)) dut (
    .CLOCK_50      (clk),
    .i_rst_n       (rst_n),
    .i_key_valid   (key_valid),
    .i_key_code    (key_code),
    .i_turn_active (turn),
    .i_hand_size   (hand_size),
    .i_play_ack    (play_ack),
    .i_draw_ack    (draw_ack),
    .o_cursor      (cursor),
    .o_play_req    (play_req),
    .o_draw_req    (draw_req),
    .o_timeout     (timeout),
    .o_state       (state)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One-cycle key strobe; returns on the falling edge after the capturing edge.
  task automatic key(input logic [7:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int  n;
    bit  saw_to;

    rst_n = 1'b0; key_valid = 1'b0; key_code = 8'h00; turn = 1'b0;
    hand_size = 7'd5; play_ack = 1'b0; draw_ack = 1'b0;
    tick(3);
    check("rst_state",    16'(state),    16'd0);
    check("rst_cursor",   16'(cursor),   16'd0);
    check("rst_play_req", 16'(play_req), 16'd0);
    check("rst_draw_req", 16'(draw_req), 16'd0);
    check("rst_timeout",  16'(timeout),  16'd0);

    // Keys are ignored in IDLE.
    rst_n = 1'b1;
    key(8'h1D);
    check("idle_key_cursor", 16'(cursor), 16'd0);
    check("idle_key_state",  16'(state),  16'd0);

    turn = 1'b1;
    tick(1);
    check("idle_to_select", 16'(state), 16'd1);

    // Wrap in both directions with hand_size=5.
    key(8'h1B);
    check("prev_wrap_to_4", 16'(cursor), 16'd4);
    key(8'h1D);
    check("next_wrap_to_0", 16'(cursor), 16'd0);
    key(8'h1B);
    check("prev_wrap_again", 16'(cursor), 16'd4);
    key(8'h1D); key(8'h1D); key(8'h1D);
    check("cursor_at_2", 16'(cursor), 16'd2);

    // Break code swallows exactly one following byte.
    key(8'hF0);
    check("break_prefix", 16'(cursor), 16'd2);
    key(8'h1D);
    check("break_discard", 16'(cursor), 16'd2);
    key(8'h1D);
    check("after_break", 16'(cursor), 16'd3);

    key(8'h44);
    check("unknown_state",  16'(state),  16'd1);
    check("unknown_cursor", 16'(cursor), 16'd3);

    // Play handshake: keys, wrong ack ignored; ack with turn low goes IDLE.
    key(8'h5A);
    check("play_req_set", 16'(play_req), 16'd1);
    check("play_state",   16'(state),    16'd2);
    check("play_no_draw", 16'(draw_req), 16'd0);
    key(8'h1D);
    check("play_frozen", 16'(cursor), 16'd3);
    key(8'hF0);  // break flag armed during the wait
    draw_ack = 1'b1; tick(1); draw_ack = 1'b0;
    check("wrong_ack_req",   16'(play_req), 16'd1);
    check("wrong_ack_state", 16'(state),    16'd2);
    turn = 1'b0;
    play_ack = 1'b1; tick(1); play_ack = 1'b0;
    check("ack_req_drop", 16'(play_req), 16'd0);
    check("ack_to_idle",  16'(state),    16'd0);
    check("ack_no_to",    16'(timeout),  16'd0);

    turn = 1'b1;
    tick(1);
    key(8'h1D);  // discarded by the break flag set in PLAY_WAIT
    check("break_kept_wait", 16'(cursor), 16'd3);

    // Draw timeout: request high for 16 cycles, then a one-cycle pulse.
    key(8'h23);
    check("draw_state", 16'(state), 16'd3);
    n = 0;
    while (draw_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("draw_high_cycles", 16'(n),       16'd16);
    check("to_pulse",         16'(timeout), 16'd1);
    check("to_state",         16'(state),   16'd1);
    tick(1);
    check("to_one_cycle", 16'(timeout), 16'd0);

    // Ack arriving in the timeout cycle wins.
    key(8'h23);
    tick(15);
    draw_ack = 1'b1; tick(1); draw_ack = 1'b0;
    check("ack_vs_to_pulse", 16'(timeout),  16'd0);
    check("ack_vs_to_req",   16'(draw_req), 16'd0);
    check("ack_vs_to_state", 16'(state),    16'd1);

    // Clamp when the hand shrinks; empty hand blocks play.
    hand_size = 7'd8;
    key(8'h1D); key(8'h1D); key(8'h1D);
    check("cursor_at_6", 16'(cursor), 16'd6);
    hand_size = 7'd4;
    tick(1);
    check("clamp_to_3", 16'(cursor), 16'd3);
    hand_size = 7'd0;
    tick(1);
    check("empty_cursor", 16'(cursor), 16'd0);
    key(8'h5A);
    check("empty_no_play", 16'(play_req), 16'd0);
    check("empty_state",   16'(state),    16'd1);

    // Reset mid-handshake abandons the request silently.
    hand_size = 7'd5;
    key(8'h5A);
    check("play2_req", 16'(play_req), 16'd1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_state",  16'(state),    16'd0);
    check("midrst_req",    16'(play_req), 16'd0);
    check("midrst_cursor", 16'(cursor),   16'd0);
    saw_to = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(negedge clk);
      if (timeout) saw_to = 1'b1;
    end
    check("midrst_no_to",    16'(saw_to), 16'd0);
    check("post_rst_select", 16'(state),  16'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hand_select_ctrl.md
HAND_SELECT_CTRL -- requirements
Module: hand_select_ctrl

Interface
REQ-001 Parameter KEY_NEXT, default 8'h1D, scancode that moves the cursor to the next card.
REQ-002 Parameter KEY_PREV, default 8'h1B, scancode that moves the cursor to the previous card.
REQ-003 Parameter KEY_PLAY, default 8'h5A, scancode that requests play of the card under the cursor.
REQ-004 Parameter KEY_DRAW, default 8'h23, scancode that requests a card draw.
REQ-005 Parameter TIMEOUT, default 16'd50000, number of wait-state cycles before a request is abandoned.
REQ-006 Port CLOCK_50, input, 1, the single clock.
REQ-007 Port i_rst_n, input, 1, reset; synchronous and active-low.
REQ-008 Port i_key_valid, input, 1, one-cycle strobe marking a new byte from the keyboard decoder.
REQ-009 Port i_key_code, input, 8, received scancode byte; sampled only when i_key_valid=1.
REQ-010 Port i_turn_active, input, 1, high while it is the local player's turn.
REQ-011 Port i_hand_size, input, 7, number of cards in the hand (0..127).
REQ-012 Port i_play_ack, input, 1, one-cycle acknowledge of o_play_req from game logic.
REQ-013 Port i_draw_ack, input, 1, one-cycle acknowledge of o_draw_req from game logic.
REQ-014 Port o_cursor, output, 7, index of the selected card.
REQ-015 Port o_play_req, output, 1, level request to play card o_cursor.
REQ-016 Port o_draw_req, output, 1, level request to draw a card.
REQ-017 Port o_timeout, output, 1, one-cycle pulse when a request is abandoned.
REQ-018 Port o_state, output, 2, current FSM state encoding.

Function
REQ-019 The FSM SHALL have four states: IDLE=0, SELECT=1, PLAY_WAIT=2, DRAW_WAIT=3.
REQ-020 In IDLE, the FSM SHALL move to SELECT on the first cycle that i_turn_active=1; all keys are ignored in IDLE.
REQ-021 In SELECT, if i_turn_active=0, the FSM SHALL return to IDLE, and this SHALL take priority over any key in the same cycle.
REQ-022 Break-code handling: a valid byte 8'hF0 SHALL set a break flag, the next valid byte SHALL be discarded and clear the flag, and the flag SHALL be kept in every state.
REQ-023 In SELECT, a valid non-break KEY_NEXT SHALL set o_cursor to o_cursor+1, wrapping to 0 when o_cursor = i_hand_size-1.
REQ-024 In SELECT, a valid non-break KEY_PREV SHALL set o_cursor to o_cursor-1, wrapping to i_hand_size-1 when o_cursor = 0.
REQ-025 When i_hand_size=0, o_cursor SHALL be held at 0 and KEY_NEXT, KEY_PREV and KEY_PLAY SHALL be ignored.
REQ-026 If i_hand_size>0 and o_cursor >= i_hand_size, in any state except PLAY_WAIT, o_cursor SHALL be clamped to i_hand_size-1 on the next edge; this clamp SHALL take priority over a same-cycle move.
REQ-027 In SELECT, a valid KEY_PLAY with i_hand_size>0 SHALL assert o_play_req from the next cycle and enter PLAY_WAIT.
REQ-028 In SELECT, a valid KEY_DRAW SHALL assert o_draw_req from the next cycle and enter DRAW_WAIT.
REQ-029 In SELECT, unrecognised codes SHALL cause no state or output change.
REQ-030 o_play_req and o_draw_req SHALL be mutually exclusive.
REQ-031 o_play_req and o_draw_req SHALL each hold high until the matching ack or the timeout.
REQ-032 o_cursor SHALL be frozen throughout PLAY_WAIT.
REQ-033 In PLAY_WAIT or DRAW_WAIT, all keys SHALL be ignored, except that they still update the break flag.
REQ-034 In PLAY_WAIT or DRAW_WAIT, a non-matching ack SHALL be ignored.
REQ-035 On the matching ack, the request SHALL deassert on the next edge and the FSM SHALL go to SELECT if i_turn_active=1, else to IDLE.
REQ-036 A matching ack SHALL be honoured even if i_turn_active fell during the wait.
REQ-037 A 16-bit wait counter SHALL clear on entry to a wait state and increment each cycle spent in it.
REQ-038 When the wait counter reaches TIMEOUT-1 without a matching ack, the request SHALL drop and o_timeout SHALL pulse for one cycle.
REQ-039 After a timeout, the FSM SHALL go to SELECT or IDLE using the same rule as REQ-035.
REQ-040 If an ack and the timeout occur in the same cycle, the ack SHALL win and o_timeout SHALL stay 0.
REQ-041 o_state SHALL reflect the registered state with no extra latency.

Reset
REQ-042 While i_rst_n=0 at a rising edge of CLOCK_50: state=IDLE, o_cursor=0, o_play_req=0, o_draw_req=0, o_timeout=0, break flag=0, wait counter=0.
REQ-043 Reset SHALL take effect mid-handshake and abandon any outstanding request without pulsing o_timeout.

Verification
REQ-044 hand_size=5, turn=1, cursor=4, KEY_NEXT -> cursor=0; KEY_PREV -> cursor=4.
REQ-045 Sequence F0,1D in SELECT, cursor=2 -> cursor stays 2, and the following 1D -> cursor=3.
REQ-046 cursor=3, KEY_PLAY -> o_play_req=1 next cycle and state=2; i_draw_ack ignored; i_play_ack with turn=0 -> req=0 and state=0.
REQ-047 KEY_DRAW with no ack, TIMEOUT=16 -> o_draw_req high 16 cycles, then o_timeout one-cycle pulse and state=1.
REQ-048 cursor=6, i_hand_size drops to 4 in SELECT -> cursor=3 next cycle; hand_size=0 with KEY_PLAY -> no request.
REQ-049 i_rst_n=0 during PLAY_WAIT -> all outputs at reset values at the next edge, and o_timeout never pulses.
